// File: rtl/sparse_pkg.sv
// Shared definitions for the sparse compare-and-swap/merge block.
// Holds the default index/value widths and adder latency, plus a lane
// record {valid, index, value} at the default widths. Modules that are
// parameterised away from the defaults build their own lane record with
// the same field order.
package sparse_pkg;

  localparam int DEF_ADDRW   = 10;
  localparam int DEF_WL      = 32;
  localparam int DEF_ADD_LAT = 4;

  typedef struct packed {
    logic                   valid;
    logic [DEF_ADDRW-1:0]   index;
    logic [DEF_WL-1:0]      value;
  } lane_t;

endpackage

// File: rtl/cas_adder.sv
// Pipelined WL-bit two's-complement adder with a latency of ADD_LAT
// enabled cycles. The whole pipeline advances only while ena is high, so
// it stays in lockstep with the sideband pipeline in the parent. The port
// list and latency are kept deliberately plain so a floating-point adder
// with the same interface can be dropped in.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears every stage
//   ena   - advance enable; low freezes the pipeline
//   a, b  - operands
//   sum   - a + b, wrapping mod 2^WL, ADD_LAT enabled cycles later
module cas_adder #(
  parameter int WL      = 32,
  parameter int ADD_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [WL-1:0] a,
  input  logic [WL-1:0] b,
  output logic [WL-1:0] sum
);

  logic [WL-1:0] pipe_q [ADD_LAT];

  // The sum is formed in the first stage; the remaining stages only delay it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ADD_LAT; i++) pipe_q[i] <= '0;
    end else if (ena) begin
      pipe_q[0] <= a + b;
      for (int i = 1; i < ADD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign sum = pipe_q[ADD_LAT-1];

endmodule

// File: rtl/sparse_cas.sv
// Two-lane sparse compare-and-swap with optional merge of equal indices.
// Each enabled cycle a pair of (valid, index, value) lanes is sampled,
// sorted by index (ascending or descending), and optionally merged into a
// single lane carrying the summed value when both indices match. Results
// appear on registered outputs ADD_LAT+1 enabled cycles after sampling.
// Ports:
//   clk, rst_n           - clock and asynchronous active-low reset
//   ena                  - global advance; low freezes all state
//   valid1/2, index1/2,
//   value1/2             - input lanes
//   descend              - 0 ascending, 1 descending
//   merge_en             - allow summing of equal indices
//   cnt_clr              - synchronous clear of merge_cnt (ignores ena)
//   outvalid/index/value - registered sorted (or merged) lanes
//   merged               - current output pair is a merge result
//   merge_cnt            - saturating count of merges
module sparse_cas
  import sparse_pkg::*;
#(
  parameter int ADDRW   = DEF_ADDRW,
  parameter int WL      = DEF_WL,
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             valid1,
  input  logic             valid2,
  input  logic [ADDRW-1:0] index1,
  input  logic [ADDRW-1:0] index2,
  input  logic [WL-1:0]    value1,
  input  logic [WL-1:0]    value2,
  input  logic             descend,
  input  logic             merge_en,
  input  logic             cnt_clr,
  output logic             outvalid1,
  output logic             outvalid2,
  output logic [ADDRW-1:0] outindex1,
  output logic [ADDRW-1:0] outindex2,
  output logic [WL-1:0]    outvalue1,
  output logic [WL-1:0]    outvalue2,
  output logic             merged,
  output logic [CNTW-1:0]  merge_cnt
);

  // Lane record at this instance's widths; same field order as lane_t.
  typedef struct packed {
    logic             valid;
    logic [ADDRW-1:0] index;
    logic [WL-1:0]    value;
  } slot_t;

  typedef struct packed {
    slot_t l1;
    slot_t l2;
    logic  merge;
  } stage_t;

  slot_t         in1, in2;
  logic          swap;
  stage_t        stage_d;
  stage_t        stage_q [ADD_LAT];
  stage_t        tail;
  logic [WL-1:0] addSum;

  slot_t         out1_d, out2_d, out1_q, out2_q;
  logic          merged_d, merged_q;
  logic [CNTW-1:0] cnt_d, cnt_q;

  // Invalid lanes are scrubbed to zero so nothing stale travels downstream.
  // The swap only fires on a strict inequality, which keeps input order for
  // equal indices.
  always_comb begin
    in1       = '0;
    in2       = '0;
    swap      = 1'b0;
    stage_d   = '0;
    if (valid1) in1 = '{valid: 1'b1, index: index1, value: value1};
    if (valid2) in2 = '{valid: 1'b1, index: index2, value: value2};
    if (valid1 && valid2) begin
      swap          = descend ? (index2 > index1) : (index2 < index1);
      stage_d.l1    = swap ? in2 : in1;
      stage_d.l2    = swap ? in1 : in2;
      stage_d.merge = merge_en && (index1 == index2);
    end else if (valid2) begin
      stage_d.l1 = in2;
    end else begin
      stage_d.l1 = in1;
    end
  end

  // The sum operands come straight from the inputs so that the adder result
  // lands at the same enabled cycle as the last sideband stage, letting the
  // output register pick it up without an extra cycle.
  cas_adder #(
    .WL      (WL),
    .ADD_LAT (ADD_LAT)
  ) u_adder (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .a     (value1),
    .b     (value2),
    .sum   (addSum)
  );

  // Sideband pipeline: sorted lanes plus merge flag, ADD_LAT stages deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ADD_LAT; i++) stage_q[i] <= '0;
    end else if (ena) begin
      stage_q[0] <= stage_d;
      for (int i = 1; i < ADD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tail = stage_q[ADD_LAT-1];

  // A merge collapses the pair into lane 1 with the summed value.
  always_comb begin
    out1_d   = tail.l1;
    out2_d   = tail.l2;
    merged_d = 1'b0;
    if (tail.merge) begin
      out1_d.value = addSum;
      out2_d       = '0;
      merged_d     = 1'b1;
    end
  end

  // Clear wins over increment and acts even while the pipeline is frozen.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (ena && merged_d && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_q   <= '0;
      out2_q   <= '0;
      merged_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (ena) begin
        out1_q   <= out1_d;
        out2_q   <= out2_d;
        merged_q <= merged_d;
      end
    end
  end

  assign outvalid1 = out1_q.valid;
  assign outindex1 = out1_q.index;
  assign outvalue1 = out1_q.value;
  assign outvalid2 = out2_q.valid;
  assign outindex2 = out2_q.index;
  assign outvalue2 = out2_q.value;
  assign merged    = merged_q;
  assign merge_cnt = cnt_q;

endmodule

// File: tb/tb_sparse_cas.sv
// Directed self-checking bench for sparse_cas. A behavioural model computes
// the expected output pair for every enabled input cycle and pushes it to a
// scoreboard queue; entries are popped as the DUT advances. A second
// instance with a 2-bit merge counter exercises saturation.
module tb_sparse_cas;
  import sparse_pkg::*;

  localparam int LAT = DEF_ADD_LAT;

  typedef struct packed {
    lane_t o1;
    lane_t o2;
    logic  merged;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, valid1, valid2, descend, merge_en, cnt_clr;
  logic [9:0]  index1, index2;
  logic [31:0] value1, value2;

  logic        outvalid1, outvalid2, merged;
  logic [9:0]  outindex1, outindex2;
  logic [31:0] outvalue1, outvalue2;
  logic [15:0] merge_cnt;

  logic        outvalid1Sat, outvalid2Sat, mergedSat;
  logic [9:0]  outindex1Sat, outindex2Sat;
  logic [31:0] outvalue1Sat, outvalue2Sat;
  logic [1:0]  merge_cntSat;

  int          checks   = 0;
  int          failures = 0;
  exp_t        expQ[$];
  exp_t        curExp;
  logic [15:0] cntModel;
  logic [1:0]  cntSatModel;

  always #5 clk = ~clk;

  sparse_cas dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .valid1(valid1), .valid2(valid2),
    .index1(index1), .index2(index2),
    .value1(value1), .value2(value2),
    .descend(descend), .merge_en(merge_en), .cnt_clr(cnt_clr),
    .outvalid1(outvalid1), .outvalid2(outvalid2),
    .outindex1(outindex1), .outindex2(outindex2),
    .outvalue1(outvalue1), .outvalue2(outvalue2),
    .merged(merged), .merge_cnt(merge_cnt)
  );

  sparse_cas #(.CNTW(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .valid1(valid1), .valid2(valid2),
    .index1(index1), .index2(index2),
    .value1(value1), .value2(value2),
    .descend(descend), .merge_en(merge_en), .cnt_clr(cnt_clr),
    .outvalid1(outvalid1Sat), .outvalid2(outvalid2Sat),
    .outindex1(outindex1Sat), .outindex2(outindex2Sat),
    .outvalue1(outvalue1Sat), .outvalue2(outvalue2Sat),
    .merged(mergedSat), .merge_cnt(merge_cntSat)
  );

  // Reference behaviour for one sampled input pair.
  function automatic exp_t model(input logic v1, input logic [9:0] i1,
                                 input logic [31:0] x1, input logic v2,
                                 input logic [9:0] i2, input logic [31:0] x2,
                                 input logic desc, input logic men);
    exp_t  e;
    lane_t a, b;
    e = '0;
    a = v1 ? {1'b1, i1, x1} : '0;
    b = v2 ? {1'b1, i2, x2} : '0;
    if (v1 && v2) begin
      if (i1 == i2 && men) begin
        e.o1     = {1'b1, i1, x1 + x2};
        e.merged = 1'b1;
      end else if (i1 == i2 || ((i1 < i2) ^ desc)) begin
        e.o1 = a;
        e.o2 = b;
      end else begin
        e.o1 = b;
        e.o2 = a;
      end
    end else if (v2) begin
      e.o1 = b;
    end else begin
      e.o1 = a;
    end
    return e;
  endfunction

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkEq("out1",   {outvalid1, outindex1, outvalue1}, curExp.o1);
    checkEq("out2",   {outvalid2, outindex2, outvalue2}, curExp.o2);
    checkEq("merged", merged, curExp.merged);
    checkEq("cnt",    merge_cnt, cntModel);
    checkEq("satLanes", {outvalid1Sat, outindex1Sat, outvalue1Sat,
                         outvalid2Sat, outindex2Sat, outvalue2Sat, mergedSat},
                        {curExp.o1, curExp.o2, curExp.merged});
    checkEq("satCnt", merge_cntSat, cntSatModel);
  endtask

  // After reset the pipeline holds LAT empty stages.
  task automatic resetModel();
    expQ.delete();
    repeat (LAT) expQ.push_back('0);
    curExp      = '0;
    cntModel    = '0;
    cntSatModel = '0;
  endtask

  task automatic clockStep();
    if (ena) expQ.push_back(model(valid1, index1, value1, valid2, index2, value2,
                                  descend, merge_en));
    @(posedge clk);
    #1;
    if (ena) curExp = expQ.pop_front();
    if (cnt_clr) begin
      cntModel    = '0;
      cntSatModel = '0;
    end else if (ena && curExp.merged) begin
      if (cntModel != 16'hFFFF) cntModel = cntModel + 16'd1;
      if (cntSatModel != 2'b11) cntSatModel = cntSatModel + 2'd1;
    end
    checkOutput();
  endtask

  task automatic applyStimulus(input logic v1, input logic [9:0] i1, input logic [31:0] x1,
                               input logic v2, input logic [9:0] i2, input logic [31:0] x2);
    valid1 = v1; index1 = i1; value1 = x1;
    valid2 = v2; index2 = i2; value2 = x2;
    clockStep();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 10'd0, 32'd0, 1'b0, 10'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; descend = 1'b0; merge_en = 1'b0; cnt_clr = 1'b0;
    valid1 = 1'b0; valid2 = 1'b0; index1 = '0; index2 = '0; value1 = '0; value2 = '0;
    resetModel();
    #12;
    checkOutput();
    rst_n = 1'b1;
    @(negedge clk);

    // Ascending sort, visible exactly LAT+1 cycles after sampling.
    applyStimulus(1'b1, 10'd7, 32'd10, 1'b1, 10'd3, 32'd20);
    idle(LAT - 1);
    checkEq("sortLatEarly", outvalid1, 1'b0);
    idle(1);
    checkEq("sortIdx1", outindex1, 10'd3);
    checkEq("sortVal1", outvalue1, 32'd20);
    checkEq("sortIdx2", outindex2, 10'd7);
    checkEq("sortVal2", outvalue2, 32'd10);
    checkEq("sortMerged", merged, 1'b0);

    // Merge of equal indices.
    merge_en = 1'b1;
    applyStimulus(1'b1, 10'd5, 32'd100, 1'b1, 10'd5, 32'd23);
    idle(LAT);
    checkEq("mergeOut1", {outvalid1, outindex1, outvalue1}, {1'b1, 10'd5, 32'd123});
    checkEq("mergeOut2", {outvalid2, outindex2, outvalue2}, 43'd0);
    checkEq("mergeFlag", merged, 1'b1);
    checkEq("mergeCnt", merge_cnt, 16'd1);

    // Descending, only lane 2 valid; lane 1 carries junk that must vanish.
    descend = 1'b1;
    applyStimulus(1'b0, 10'd12, 32'd99, 1'b1, 10'd9, 32'd44);
    idle(LAT);
    checkEq("onlyV2Out1", {outvalid1, outindex1, outvalue1}, {1'b1, 10'd9, 32'd44});
    checkEq("onlyV2Out2", {outvalid2, outindex2, outvalue2}, 43'd0);

    // Back-to-back mix: descending swap, equal without merge, lane1 only, wrap.
    applyStimulus(1'b1, 10'd2, 32'd5, 1'b1, 10'd8, 32'd6);
    merge_en = 1'b0;
    applyStimulus(1'b1, 10'd6, 32'd1, 1'b1, 10'd6, 32'd2);
    descend = 1'b0;
    applyStimulus(1'b1, 10'd4, 32'd7, 1'b0, 10'd3, 32'd3);
    merge_en = 1'b1;
    applyStimulus(1'b1, 10'd9, 32'hFFFF_FFFF, 1'b1, 10'd9, 32'd2);
    applyStimulus(1'b1, 10'd1023, 32'd1, 1'b1, 10'd0, 32'd2);
    idle(LAT);

    // Stream of six pairs with a three-cycle freeze in the middle.
    merge_en = 1'b0;
    for (int k = 0; k < 9; k++) begin
      ena = !(k >= 3 && k < 6);
      applyStimulus(1'b1, 10'(k * 37 + 5), 32'(k + 100),
                    1'b1, 10'(300 - k * 11), 32'(k + 200));
    end
    ena = 1'b1;
    idle(LAT + 1);

    // Saturation of the 2-bit counter, then clear while frozen.
    merge_en = 1'b1;
    for (int k = 0; k < 5; k++)
      applyStimulus(1'b1, 10'(k + 40), 32'(k), 1'b1, 10'(k + 40), 32'd1);
    idle(LAT);
    checkEq("satAt3", merge_cntSat, 2'd3);
    checkEq("cntAt7", merge_cnt, 16'd7);
    ena = 1'b0;
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    ena = 1'b1;
    checkEq("clrSat", merge_cntSat, 2'd0);
    checkEq("clrCnt", merge_cnt, 16'd0);

    // Reset with pairs in flight: outputs drop at once, nothing stale follows.
    applyStimulus(1'b1, 10'd11, 32'd1, 1'b1, 10'd11, 32'd2);
    applyStimulus(1'b1, 10'd12, 32'd3, 1'b1, 10'd13, 32'd4);
    applyStimulus(1'b1, 10'd14, 32'd5, 1'b0, 10'd0, 32'd0);
    idle(1);
    #1;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    idle(LAT + 2);
    applyStimulus(1'b1, 10'd20, 32'd8, 1'b1, 10'd21, 32'd9);
    idle(LAT + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
